// File: rtl/ssd_display_ctrl.sv
// Four-digit common-anode seven-segment controller: hex or unsigned-decimal view of a
// 16-bit probe value, converted by double-dabble into a double-buffered display register.
module ssd_display_ctrl #(
  parameter int unsigned DIGIT_CYCLES = 100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] value,
  input  logic        dec_mode,
  output logic [3:0]  anode,
  output logic [6:0]  cathode,
  output logic        dp,
  output logic        busy
);

  localparam int unsigned CW = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DIGIT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CONVERT,
    S_LOAD
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [CW-1:0]   r_cnt;
  logic [1:0]      r_idx;
  logic            w_frame;
  logic [15:0]     r_val;
  logic            r_dec;
  logic [15:0]     r_bin;
  logic [19:0]     r_bcd;
  logic [19:0]     w_bcd_adj;
  logic [3:0]      r_step;
  logic [3:0][6:0] r_seg;
  logic            r_dp_n;
  logic            r_valid;
  logic [3:0][6:0] w_code;
  logic [3:0]      w_blank;
  logic            w_ovf;

  function automatic logic [6:0] f_seg(input logic [3:0] d);
    case (d)
      4'h0: f_seg = 7'b1000000;
      4'h1: f_seg = 7'b1111001;
      4'h2: f_seg = 7'b0100100;
      4'h3: f_seg = 7'b0110000;
      4'h4: f_seg = 7'b0011001;
      4'h5: f_seg = 7'b0010010;
      4'h6: f_seg = 7'b0000010;
      4'h7: f_seg = 7'b1111000;
      4'h8: f_seg = 7'b0000000;
      4'h9: f_seg = 7'b0010000;
      4'hA: f_seg = 7'b0001000;
      4'hB: f_seg = 7'b0000011;
      4'hC: f_seg = 7'b1000110;
      4'hD: f_seg = 7'b0100001;
      4'hE: f_seg = 7'b0000110;
      default: f_seg = 7'b0001110;
    endcase
  endfunction

  assign w_frame = (r_cnt == '0) && (r_idx == 2'd0);
  assign busy    = (r_state == S_CONVERT);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
      r_idx <= 2'd0;
    end else if (r_cnt == CNT_MAX) begin
      r_cnt <= '0;
      r_idx <= r_idx + 2'd1;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:    if (w_frame) w_state_nxt = dec_mode ? S_CONVERT : S_LOAD;
      S_CONVERT: if (r_step == 4'd15) w_state_nxt = S_LOAD;
      S_LOAD:    w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_bcd_adj = r_bcd;
    for (int unsigned i = 0; i < 5; i++) begin
      if (r_bcd[4*i +: 4] >= 4'd5) w_bcd_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
    end
  end

  // Leading-zero blanking ripples down from the top digit; digit 0 is never blanked.
  always_comb begin
    w_ovf      = r_dec && (r_bcd[19:16] != 4'd0);
    w_blank    = 4'b0000;
    w_blank[3] = (r_bcd[15:12] == 4'd0);
    w_blank[2] = w_blank[3] && (r_bcd[11:8] == 4'd0);
    w_blank[1] = w_blank[2] && (r_bcd[7:4] == 4'd0);
    w_code     = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (!r_dec)          w_code[i] = f_seg(r_val[4*i +: 4]);
      else if (w_ovf)      w_code[i] = 7'b0111111;
      else if (w_blank[i]) w_code[i] = '1;
      else                 w_code[i] = f_seg(r_bcd[4*i +: 4]);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_val   <= '0;
      r_dec   <= 1'b0;
      r_bin   <= '0;
      r_bcd   <= '0;
      r_step  <= '0;
      r_seg   <= '0;
      r_dp_n  <= 1'b1;
      r_valid <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: if (w_frame) begin
          r_val  <= value;
          r_dec  <= dec_mode;
          r_bin  <= value;
          r_bcd  <= '0;
          r_step <= '0;
        end
        S_CONVERT: begin
          {r_bcd, r_bin} <= {w_bcd_adj[18:0], r_bin, 1'b0};
          r_step         <= r_step + 4'd1;
        end
        S_LOAD: begin
          r_seg   <= w_code;
          r_dp_n  <= !w_ovf;
          r_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      anode   <= '1;
      cathode <= '1;
      dp      <= 1'b1;
    end else if (r_valid) begin
      anode   <= ~(4'b0001 << r_idx);
      cathode <= r_seg[r_idx];
      dp      <= r_dp_n;
    end else begin
      anode   <= '1;
      cathode <= '1;
      dp      <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ssd_display_ctrl.sv
// Scoreboarded bench for ssd_display_ctrl: expected digit slots come from an arithmetic
// model of the display rules and are compared as each multiplexed slot ends.
module tb_ssd_display_ctrl;
  localparam int unsigned DC = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] value;
  logic        dec_mode;
  logic [3:0]  anode;
  logic [6:0]  cathode;
  logic        dp;
  logic        busy;

  always #5 clk = ~clk;

  ssd_display_ctrl #(.DIGIT_CYCLES(DC)) dut (
    .clk(clk), .rst(rst), .value(value), .dec_mode(dec_mode),
    .anode(anode), .cathode(cathode), .dp(dp), .busy(busy)
  );

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
  } slot_t;

  slot_t sb[$];
  int    total = 0;
  int    bad = 0;
  int    busy_runs = 0;

  function automatic logic [6:0] segtab(input int d);
    case (d)
      0: return 7'b1000000;  1: return 7'b1111001;  2: return 7'b0100100;
      3: return 7'b0110000;  4: return 7'b0011001;  5: return 7'b0010010;
      6: return 7'b0000010;  7: return 7'b1111000;  8: return 7'b0000000;
      9: return 7'b0010000;  10: return 7'b0001000; 11: return 7'b0000011;
      12: return 7'b1000110; 13: return 7'b0100001; 14: return 7'b0000110;
      default: return 7'b0001110;
    endcase
  endfunction

  function automatic slot_t model(input logic [15:0] v, input logic m, input int slot);
    slot_t s;
    int    n;
    int    p;
    n = int'(v);
    p = 1;
    for (int k = 0; k < slot; k++) p = p * 10;
    s.an       = 4'b1111;
    s.an[slot] = 1'b0;
    s.dp       = 1'b1;
    if (!m) begin
      s.seg = segtab((n >> (4 * slot)) % 16);
    end else if (n >= 10000) begin
      s.seg = 7'b0111111;
      s.dp  = 1'b0;
    end else if (slot > 0 && n < p) begin
      s.seg = 7'b1111111;
    end else begin
      s.seg = segtab((n / p) % 10);
    end
    return s;
  endfunction

  task automatic push_frame(input logic [15:0] v, input logic m);
    for (int s = 0; s < 4; s++) sb.push_back(model(v, m, s));
  endtask

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", nm, got, exp);
    end
  endtask

  task automatic wait_digit(input logic [3:0] an);
    logic [3:0] p;
    int         n;
    p = anode;
    n = 0;
    forever begin
      @(negedge clk);
      if (anode == an && p != an) return;
      p = anode;
      n++;
      if (n > 400) begin
        total++;
        bad++;
        $display("FAIL wait_anode_%b: timed out, anode=%b", an, anode);
        return;
      end
    end
  endtask

  task automatic run_item(input logic [15:0] v, input logic m);
    value    = v;
    dec_mode = m;
    wait_digit(4'b1110);
    wait_digit(4'b1110);
    @(posedge clk);
    push_frame(v, m);
    wait_digit(4'b1110);
  endtask

  // Monitor: a slot is judged on its last cycle, once the anode moves on.
  initial begin : monitor
    logic [3:0] pa;
    logic [6:0] pc;
    logic       pd;
    int         run;
    slot_t      e;
    pa  = 4'b1111;
    pc  = '1;
    pd  = 1'b1;
    run = 0;
    forever begin
      @(negedge clk);
      if (anode != pa && $countones(~pa) == 1 && sb.size() > 0) begin
        e = sb.pop_front();
        total++;
        if ({pa, pc, pd} !== e) begin
          bad++;
          $display("FAIL slot: got anode=%b cathode=%b dp=%b want anode=%b cathode=%b dp=%b",
                   pa, pc, pd, e.an, e.seg, e.dp);
        end
      end
      pa = anode;
      pc = cathode;
      pd = dp;
      if (!rst) begin
        run = 0;
      end else if (busy) begin
        run++;
      end else if (run != 0) begin
        busy_runs++;
        total++;
        if (run != 16) begin
          bad++;
          $display("FAIL busy_len: got=%0d want=16", run);
        end
        run = 0;
      end
    end
  end

  initial begin : stim
    logic [15:0] v;
    logic        m;
    int          n;
    rst      = 1'b0;
    value    = 16'h1234;
    dec_mode = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_anode", 32'(anode), 32'hF);
    chk("rst_cathode", 32'(cathode), 32'h7F);
    chk("rst_dp", 32'(dp), 32'h1);
    chk("rst_busy", 32'(busy), 32'h0);
    rst = 1'b1;
    wait_digit(4'b1110);

    run_item(16'h1234, 1'b0);
    run_item(16'd1234, 1'b1);
    run_item(16'd7, 1'b1);
    run_item(16'd10000, 1'b1);
    run_item(16'd65535, 1'b1);
    run_item(16'hFFFF, 1'b0);
    run_item(16'h00AA, 1'b0);

    // Value changed mid-frame must not reach the display before the next frame start.
    @(posedge clk);
    push_frame(16'h00AA, 1'b0);
    wait_digit(4'b1011);
    value = 16'h0055;
    wait_digit(4'b1110);
    @(posedge clk);
    push_frame(16'h0055, 1'b0);
    wait_digit(4'b1110);

    // Reset in the middle of a decimal conversion.
    value    = 16'd9999;
    dec_mode = 1'b1;
    n = 0;
    while (!busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("busy_start", 32'(busy), 32'h1);
    repeat (7) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("arst_anode", 32'(anode), 32'hF);
    chk("arst_cathode", 32'(cathode), 32'h7F);
    chk("arst_dp", 32'(dp), 32'h1);
    chk("arst_busy", 32'(busy), 32'h0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    wait_digit(4'b1110);
    @(posedge clk);
    push_frame(16'd9999, 1'b1);
    wait_digit(4'b1110);

    for (int i = 0; i < 12; i++) begin
      v = 16'($urandom);
      m = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 2) == 0) v = 16'($urandom_range(0, 120));
      run_item(v, m);
    end

    repeat (40) @(negedge clk);
    chk("sb_drained", 32'(sb.size()), 32'h0);
    chk("busy_seen", 32'(busy_runs > 0), 32'h1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ssd_display_ctrl.md
Name: ssd_display_ctrl

Overview:
- Seven-segment display controller sitting directly downstream of the full datapath on the FPGA board.
- Consumes one 16-bit debug value, chosen at top level from the datapath's probe outputs (PC, ALU result, write data, etc.).
- Converts the value to four hex or decimal digits and time-multiplexes them onto a 4-digit common-anode display.
- Conversion is sequential (double-dabble) and double-buffered, so displayed digits never tear.

Parameters:
- DIGIT_CYCLES, 100000, clock cycles each digit stays lit; legal minimum 8.

Ports:
- clk      input   1   system clock
- rst      input   1   asynchronous, active-low reset
- value    input   16  value to display, sampled once per frame
- dec_mode input   1   1 = unsigned decimal, 0 = hex; sampled with value
- anode    output  4   digit enables, active-low; anode[0] = rightmost (least significant) digit
- cathode  output  7   segments {g,f,e,d,c,b,a}, active-low
- dp       output  1   decimal point, active-low
- busy     output  1   high while a decimal conversion is running

Behaviour:
- Reset (rst=0, async), all outputs and state forced as follows:
  - anode=4'b1111, cathode=7'b1111111, dp=1, busy=0.
  - Refresh counter=0, digit index=0, state=IDLE.
  - Display register=0, valid=0.
- Refresh:
  - Cycle counter runs 0..DIGIT_CYCLES-1 and advances the digit index 0→1→2→3→0 on wrap.
  - Frame start = counter==0 and index==0. This includes the first clock edge after reset release.
- FSM states:
  - IDLE: on frame start, latch value and dec_mode into shadow registers.
    - Hex mode: go to LOAD.
    - Decimal mode: clear the 20-bit BCD register and go to CONVERT.
  - CONVERT: busy=1. Each cycle, add 3 to every BCD nibble >=5, then shift {bcd,bin} left 1. Exactly 16 cycles, then go to LOAD.
  - LOAD: one cycle. Write the four digit codes into the display register, set valid=1, busy=0, go to IDLE.
- Latency from latching edge to display register update: 1 cycle in hex, 17 cycles in decimal. DIGIT_CYCLES>=8 guarantees completion inside a frame.
- Frame start during a conversion cannot occur at legal DIGIT_CYCLES. Nevertheless, any frame start not in IDLE is ignored.
- Digit codes:
  - Hex: nibble i of the shadow value goes to digit i. No blanking.
  - Decimal <=9999: BCD nibbles 0..3. Leading zeros blanked (cathode all 1s), except digit 0 is always shown.
  - Decimal >=10000 (overflow): every digit shows a dash (7'b0111111) and dp=0 on all digits.
  - Otherwise dp=1.
- Segment encodings: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
- Outputs are registered from the display register and digit index.
  - While valid=0: anode=1111.
  - Otherwise exactly one anode bit is low: anode[index]=0.
- value/dec_mode changes between frame starts have no effect until the next frame start.
- Reset mid-CONVERT aborts immediately. The partial result is discarded and valid=0 until the first LOAD after release.

Test Plan (DIGIT_CYCLES=8):
- Reset, then hex 16'h1234:
  - During rst=0: anode=1111, cathode=1111111, dp=1, busy=0.
  - After release, outputs are valid after the LOAD cycle. The digit-0 slot shows anode=1110, cathode=0011001 ('4'). The digit-3 slot shows anode=0111, cathode=1111001 ('1').
- Decimal 16'd1234:
  - busy high exactly 16 consecutive cycles, display register updated on the 17th.
  - Slots 0..3 show 0011001, 0110000, 0100100, 1111001.
- Decimal 16'd7:
  - Digit 0 shows 1111000.
  - Digits 1..3 have their anode asserted with cathode=1111111.
  - dp=1 throughout.
- Decimal 16'd10000, then 16'd65535: every slot shows cathode=0111111 with dp=0. Hex 16'hFFFF shows 0001110 on all four digits with dp=1.
- Value changed from 16'h00AA to 16'h0055 during digit 2 of a frame:
  - Digits 2 and 3 of that frame still show the old code.
  - Digit 0 shows 0010010 ('5') only in the next frame.
- rst pulsed low at CONVERT cycle 8 of decimal 16'd9999:
  - Outputs return to reset values asynchronously, without waiting for a clock edge.
  - After release, a fresh conversion shows 0010000 on all four digits.
